reg_writeback_unit: RTL and testbench
=====================================

// Module: reg_writeback_unit
// PURPOSE
//  Producer side of the register bank write port (regWrite/a3/wd3). Merges single-cycle ALU
//  results and variable-latency slow results (load/mul) into one registered write per cycle.
//  Keeps a busy scoreboard for outstanding slow destinations and forwards the in-flight write
//  to the two read ports, because the bank's reads only see a write after the clock edge.
// PARAMETERS
//  XLEN          32  data width
//  SLOW_DEPTH    2   slow-result FIFO entries (power of 2, >=2)
//  STARVE_LIMIT  4   consecutive ALU wins with slow FIFO non-empty before a forced drain
// PORTS
//  clk        in   1     clock, all state updates on posedge
//  rst_n      in   1     synchronous reset, active-low
//  alu_valid  in   1     ALU result present
//  alu_ready  out  1     ALU result accepted this cycle (ALU holds when low)
//  alu_rd     in   5     ALU destination
//  alu_data   in   XLEN  ALU result
//  slow_valid in   1     slow result present
//  slow_ready out  1     slow result accepted (= !fifo_full)
//  slow_rd    in   5     slow destination
//  slow_data  in   XLEN  slow result
//  iss_valid  in   1     slow op issued, reserve destination
//  iss_rd     in   5     reserved destination
//  reg_write  out  1     to bank regWrite
//  wr_addr    out  5     to bank a3
//  wr_data    out  XLEN  to bank wd3
//  q1_addr    in   5     bank a1 mirror;  q2_addr in 5  bank a2 mirror
//  q1_busy    out  1     busy[q1_addr];   q2_busy out 1  busy[q2_addr]
//  q1_fwd     out  1     reg_write && wr_addr==q1_addr && q1_addr!=0; q2_fwd likewise
//  fwd_data   out  XLEN  = wr_data (valid when q*_fwd)
//  waw_err    out  1     sticky: ALU write accepted to a busy register
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): reg_write=0, wr_addr=0, wr_data=0, busy=0, FIFO empty,
//    starve count=0, waw_err=0. slow_ready/alu_ready are combinational and read 1 after reset.
//  - Outputs reg_write/wr_addr/wr_data are registered: latency 1 from acceptance to bank write.
//  - Selection each cycle, in priority:
//    1 forced drain: starve==STARVE_LIMIT && FIFO non-empty -> alu_ready=0, pop FIFO head.
//    2 alu_valid -> accept ALU (alu_ready=1).
//    3 FIFO non-empty -> pop head.
//    4 FIFO empty && slow_valid -> bypass slow input directly into output regs (no FIFO write).
//    5 none -> reg_write<=0; wr_addr/wr_data hold.
//  - A slow_valid not selected in case 4 is pushed if slow_ready; push and pop together allowed.
//  - slow_ready = !full. When full it stays 0 even if a pop happens that cycle.
//  - starve: +1 when ALU wins with FIFO non-empty; cleared on any pop or when FIFO empty.
//  - rd==0: entry consumed normally, but reg_write<=0 (x0 never written, never busy).
//  - Scoreboard: iss_valid && iss_rd!=0 sets busy[iss_rd]. Selecting a slow result clears
//    busy[rd] at the same edge. Set and clear of the same rd in one cycle: set wins.
//  - q*_busy read from current busy vector (no same-cycle issue bypass).
//  - waw_err set when an ALU result is accepted with busy[alu_rd]=1, rd!=0. Cleared only by reset.
//  - Reset mid-operation drops FIFO contents and all reservations. The next cycle has no write.
// STRUCTURE
//  - wb_pkg: XLEN, REG_ADDR_W=5, typedef wb_req_t {logic [4:0] rd; logic [XLEN-1:0] data}.
//  - Sub-module wb_fifo (sync FIFO of wb_req_t, depth SLOW_DEPTH, full/empty, same-cycle push+pop).
//  - Top holds arbiter, starve counter, 32-bit busy vector, output regs and forward compares.
// TESTING
//  1 Reset mid-stream: FIFO holds 2, busy[5]=1, rst_n=0 one cycle -> reg_write=0, busy=0,
//    slow_ready=1 next cycle.
//  2 ALU only: alu rd=3 data=0xA5A5A5A5 -> next cycle reg_write=1 wr_addr=3; q1_addr=3 gives
//    q1_fwd=1 fwd_data=0xA5A5A5A5.
//  3 Conflict: alu rd=4 and slow rd=6 same cycle, FIFO empty -> x4 written first, x6 the cycle
//    after; busy[6] clears with the x6 write.
//  4 Starvation: FIFO full (2), alu_valid held high -> 4 ALU writes, then alu_ready=0 for one
//    cycle while the FIFO head is written. slow_ready=0 until that pop.
//  5 x0 and WAW: slow rd=0 -> reg_write stays 0. iss rd=7 then alu rd=7 -> waw_err=1 (sticky).
//  6 Issue/clear race: iss rd=9 on the same cycle the slow result for rd=9 is selected ->
//    busy[9]=1 afterward.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register writeback unit.
package wb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    // One pending register write: destination and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // Source chosen to drive the write port in a given cycle.
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_DRAIN,
        SEL_ALU,
        SEL_POP,
        SEL_BYPASS
    } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; supports push and pop in the same cycle.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    wb_req_t        mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Status flags from pointer comparison; the extra MSB separates full from empty.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        head    = mem[rd_ptr[AW-1:0]];
        do_push = push && !full;
        do_pop  = pop && !empty;
    end

    // Pointer update; reset discards any stored entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_req;
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Merges ALU and slow (load/mul) results into one registered register-bank write per
// cycle, tracks outstanding slow destinations and forwards the in-flight write.
module reg_writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned SLOW_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  slow_valid,
    output logic                  slow_ready,
    input  logic [REG_ADDR_W-1:0] slow_rd,
    input  logic [XLEN-1:0]       slow_data,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [XLEN-1:0]       wr_data,
    input  logic [REG_ADDR_W-1:0] q1_addr,
    input  logic [REG_ADDR_W-1:0] q2_addr,
    output logic                  q1_busy,
    output logic                  q2_busy,
    output logic                  q1_fwd,
    output logic                  q2_fwd,
    output logic [XLEN-1:0]       fwd_data,
    output logic                  waw_err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    wb_req_t        fifo_head;
    wb_req_t        slow_req;
    wb_req_t        win;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_push;
    logic           fifo_pop;
    logic           slow_sel;
    logic           force_drain;
    wb_sel_e        sel;
    logic [SW-1:0]  starve;
    logic [31:0]    busy;
    logic [31:0]    busy_set;
    logic [31:0]    busy_clr;
    logic [31:0]    busy_next;

    assign slow_req = '{rd: slow_rd, data: slow_data};

    wb_fifo #(
        .DEPTH (SLOW_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_req (slow_req),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Priority arbiter: forced drain, ALU, FIFO head, then slow bypass when FIFO is empty.
    always_comb begin
        force_drain = (starve == SW'(STARVE_LIMIT)) && !fifo_empty;
        sel         = SEL_NONE;
        win         = '0;
        if (force_drain) begin
            sel = SEL_DRAIN;
            win = fifo_head;
        end else if (alu_valid) begin
            sel = SEL_ALU;
            win = '{rd: alu_rd, data: alu_data};
        end else if (!fifo_empty) begin
            sel = SEL_POP;
            win = fifo_head;
        end else if (slow_valid) begin
            sel = SEL_BYPASS;
            win = slow_req;
        end
        fifo_pop   = (sel == SEL_DRAIN) || (sel == SEL_POP);
        slow_sel   = fifo_pop || (sel == SEL_BYPASS);
        // A bypassed slow result is consumed directly; any other slow result queues if room.
        fifo_push  = slow_valid && (sel != SEL_BYPASS) && !fifo_full;
        alu_ready  = !force_drain;
        slow_ready = !fifo_full;
    end

    // Scoreboard next state: a same-cycle reservation overrides the completion clear.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (iss_valid && (iss_rd != '0)) busy_set[iss_rd] = 1'b1;
        if (slow_sel) busy_clr[win.rd] = 1'b1;
        busy_next    = (busy & ~busy_clr) | busy_set;
        busy_next[0] = 1'b0;
    end

    // Registered write port; x0 destinations are consumed without asserting reg_write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else if (sel == SEL_NONE) begin
            reg_write <= 1'b0;
        end else begin
            reg_write <= (win.rd != '0);
            wr_addr   <= win.rd;
            wr_data   <= win.data;
        end
    end

    // Starvation counter: counts ALU wins while slow results wait, cleared by any pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (fifo_pop || fifo_empty) begin
            starve <= '0;
        end else if (sel == SEL_ALU) begin
            starve <= starve + 1'b1;
        end
    end

    // Busy vector and sticky write-after-write flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= '0;
            waw_err <= 1'b0;
        end else begin
            busy <= busy_next;
            if ((sel == SEL_ALU) && (alu_rd != '0) && busy[alu_rd]) waw_err <= 1'b1;
        end
    end

    // Read-port lookups and forwarding of the write currently presented to the bank.
    always_comb begin
        q1_busy  = busy[q1_addr];
        q2_busy  = busy[q2_addr];
        q1_fwd   = reg_write && (wr_addr == q1_addr) && (q1_addr != '0);
        q2_fwd   = reg_write && (wr_addr == q2_addr) && (q2_addr != '0);
        fwd_data = wr_data;
    end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed self-checking bench for reg_writeback_unit.
module tb_reg_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        slow_valid;
    logic        slow_ready;
    logic [4:0]  slow_rd;
    logic [31:0] slow_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        reg_write;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  q1_addr;
    logic [4:0]  q2_addr;
    logic        q1_busy;
    logic        q2_busy;
    logic        q1_fwd;
    logic        q2_fwd;
    logic [31:0] fwd_data;
    logic        waw_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_writeback_unit #(
        .SLOW_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .slow_valid (slow_valid),
        .slow_ready (slow_ready),
        .slow_rd    (slow_rd),
        .slow_data  (slow_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .reg_write  (reg_write),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .q1_addr    (q1_addr),
        .q2_addr    (q2_addr),
        .q1_busy    (q1_busy),
        .q2_busy    (q2_busy),
        .q1_fwd     (q1_fwd),
        .q2_fwd     (q2_fwd),
        .fwd_data   (fwd_data),
        .waw_err    (waw_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle so registered and combinational outputs are stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        slow_valid = 1'b0; slow_rd = '0; slow_data = '0;
        iss_valid = 1'b0; iss_rd = '0; q1_addr = '0; q2_addr = '0;
        step(); step();
        rst_n = 1'b1; #1;
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_waw", 32'(waw_err), 32'd0);
        chk("rst_slow_ready", 32'(slow_ready), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);

        // ALU only, with forwarding
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA5A5_A5A5; q1_addr = 5'd3; q2_addr = 5'd0;
        step();
        alu_valid = 1'b0; #1;
        chk("alu_reg_write", 32'(reg_write), 32'd1);
        chk("alu_wr_addr", 32'(wr_addr), 32'd3);
        chk("alu_wr_data", wr_data, 32'hA5A5_A5A5);
        chk("alu_q1_fwd", 32'(q1_fwd), 32'd1);
        chk("alu_q2_fwd_x0", 32'(q2_fwd), 32'd0);
        chk("alu_fwd_data", fwd_data, 32'hA5A5_A5A5);
        step();
        chk("idle_reg_write", 32'(reg_write), 32'd0);
        chk("idle_q1_fwd", 32'(q1_fwd), 32'd0);

        // Conflict: ALU x4 and slow x6 together, FIFO empty
        iss_valid = 1'b1; iss_rd = 5'd6;
        step();
        iss_valid = 1'b0; q1_addr = 5'd6; #1;
        chk("conf_busy6_set", 32'(q1_busy), 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h0000_0044;
        slow_valid = 1'b1; slow_rd = 5'd6; slow_data = 32'h0000_0066;
        step();
        alu_valid = 1'b0; slow_valid = 1'b0; #1;
        chk("conf_first_addr", 32'(wr_addr), 32'd4);
        chk("conf_first_data", wr_data, 32'h0000_0044);
        chk("conf_busy6_held", 32'(q1_busy), 32'd1);
        step();
        chk("conf_second_we", 32'(reg_write), 32'd1);
        chk("conf_second_addr", 32'(wr_addr), 32'd6);
        chk("conf_second_data", wr_data, 32'h0000_0066);
        chk("conf_busy6_clr", 32'(q1_busy), 32'd0);
        chk("conf_waw_clean", 32'(waw_err), 32'd0);
        step();

        // Starvation: fill FIFO while ALU keeps winning
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_0101;
        slow_valid = 1'b1; slow_rd = 5'd11; slow_data = 32'h0000_00B1; #1;
        chk("stv_a_slow_ready", 32'(slow_ready), 32'd1);
        step();
        chk("stv_a_data", wr_data, 32'h0000_0101);
        alu_data = 32'h0000_0102; slow_rd = 5'd12; slow_data = 32'h0000_00B2;
        step();
        slow_valid = 1'b0; alu_data = 32'h0000_0103; #1;
        chk("stv_full_slow_ready", 32'(slow_ready), 32'd0);
        chk("stv_c_alu_ready", 32'(alu_ready), 32'd1);
        step();
        alu_data = 32'h0000_0104;
        step();
        alu_data = 32'h0000_0105; #1;
        chk("stv_e_alu_ready", 32'(alu_ready), 32'd1);
        step();
        chk("stv_e_data", wr_data, 32'h0000_0105);
        chk("stv_drain_alu_ready", 32'(alu_ready), 32'd0);
        chk("stv_drain_slow_ready", 32'(slow_ready), 32'd0);
        step();
        chk("stv_drain_we", 32'(reg_write), 32'd1);
        chk("stv_drain_addr", 32'(wr_addr), 32'd11);
        chk("stv_drain_data", wr_data, 32'h0000_00B1);
        chk("stv_after_alu_ready", 32'(alu_ready), 32'd1);
        chk("stv_after_slow_ready", 32'(slow_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        chk("stv_held_alu_addr", 32'(wr_addr), 32'd10);
        chk("stv_held_alu_data", wr_data, 32'h0000_0105);
        step();
        chk("stv_tail_addr", 32'(wr_addr), 32'd12);
        chk("stv_tail_data", wr_data, 32'h0000_00B2);
        step();
        chk("stv_idle_we", 32'(reg_write), 32'd0);

        // x0 slow result, then WAW on x7
        slow_valid = 1'b1; slow_rd = 5'd0; slow_data = 32'hDEAD_0000;
        step();
        slow_valid = 1'b0;
        chk("x0_no_write", 32'(reg_write), 32'd0);
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        iss_valid = 1'b0; q1_addr = 5'd7;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0077; #1;
        chk("waw_busy7", 32'(q1_busy), 32'd1);
        chk("waw_before", 32'(waw_err), 32'd0);
        step();
        alu_valid = 1'b0;
        chk("waw_set", 32'(waw_err), 32'd1);
        chk("waw_write_addr", 32'(wr_addr), 32'd7);
        step(); step();
        chk("waw_sticky", 32'(waw_err), 32'd1);

        // Issue/clear race on x9
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        q2_addr = 5'd9;
        slow_valid = 1'b1; slow_rd = 5'd9; slow_data = 32'h0000_0099;
        step();
        iss_valid = 1'b0; slow_valid = 1'b0;
        chk("race_write_addr", 32'(wr_addr), 32'd9);
        chk("race_busy9_kept", 32'(q2_busy), 32'd1);
        slow_valid = 1'b1;
        step();
        slow_valid = 1'b0;
        chk("race_busy9_cleared", 32'(q2_busy), 32'd0);

        // Reset mid-stream: FIFO full, busy[5] set
        iss_valid = 1'b1; iss_rd = 5'd5;
        step();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0000_0001;
        slow_valid = 1'b1; slow_rd = 5'd13; slow_data = 32'h0000_00D1;
        step();
        slow_rd = 5'd14; slow_data = 32'h0000_00D2;
        step();
        alu_valid = 1'b0; slow_valid = 1'b0; q1_addr = 5'd5; q2_addr = 5'd7; #1;
        chk("mid_full", 32'(slow_ready), 32'd0);
        chk("mid_busy5", 32'(q1_busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; #1;
        chk("mid_rst_we", 32'(reg_write), 32'd0);
        chk("mid_rst_busy5", 32'(q1_busy), 32'd0);
        chk("mid_rst_busy7", 32'(q2_busy), 32'd0);
        chk("mid_rst_slow_ready", 32'(slow_ready), 32'd1);
        chk("mid_rst_waw", 32'(waw_err), 32'd0);
        step();
        chk("mid_rst_no_drain", 32'(reg_write), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
